booth_mul_sequencer: RTL and testbench

Multi-cycle radix-4 (bit-pair recoded) Booth multiplier controller for the CPU ALU. It replaces a single-cycle 32x32 multiply with a 2-bits-per-cycle sequenced datapath. It accepts a start handshake from the control unit and drives busy/done so the control FSM can stall. It writes the 64-bit result as HI/LO halves for the HI and LO registers.

---
 rtl/booth_mul_sequencer.sv | 113 +++++++++++
 tb/tb_booth_mul_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/booth_mul_sequencer.sv
// rtl/booth_mul_sequencer.sv - radix-4 Booth sequenced multiplier with start/busy/done handshake
module booth_mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    localparam int PW = 2 * WIDTH;
    localparam int MW = WIDTH + 2;
    localparam int QW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH / 2 + 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [MW-1:0] m_reg;
    logic [QW-1:0] q_sr;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          sgn_reg;

    logic          accept;
    logic          last_step;
    logic [CW-1:0] n_last;
    logic [MW-1:0] sel;
    logic [PW-1:0] term;
    logic [PW-1:0] acc_sum;

    // Each partial product is sign-extended to the full product width and placed at
    // weight 4^cnt; the sum modulo 2^PW is exact because the true product fits in PW bits.
    always_comb begin
        n_last    = sgn_reg ? CW'(WIDTH / 2 - 1) : CW'(WIDTH / 2);
        last_step = (cnt == n_last);
        case (q_sr[2:0])
            3'b001, 3'b010: sel = m_reg;
            3'b011:         sel = m_reg << 1;
            3'b100:         sel = -(m_reg << 1);
            3'b101, 3'b110: sel = -m_reg;
            default:        sel = '0;
        endcase
        term    = {{(PW - MW){sel[MW-1]}}, sel} << {cnt, 1'b0};
        acc_sum = acc + term;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            product_hi <= '0;
            product_lo <= '0;
            m_reg      <= '0;
            q_sr       <= '0;
            acc        <= '0;
            cnt        <= '0;
            sgn_reg    <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
            if (accept) begin
                // Unsigned operands get two zero bits so the extra top step sees a 0 sign.
                m_reg   <= is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                     : {2'b00, multiplicand};
                q_sr    <= is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0}
                                     : {2'b00, multiplier, 1'b0};
                sgn_reg <= is_signed;
                acc     <= '0;
                cnt     <= '0;
            end else if (state == S_RUN) begin
                acc  <= acc_sum;
                q_sr <= q_sr >> 2;
                cnt  <= cnt + CW'(1);
                if (last_step) {product_hi, product_lo} <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb/tb_booth_mul_sequencer.sv - randomized self-checking bench for booth_mul_sequencer
module tb_booth_mul_sequencer;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear;
    logic         start;
    logic         is_signed;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic         busy;
    logic         done;
    logic [W-1:0] product_hi;
    logic [W-1:0] product_lo;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    always #5 clock = ~clock;

    booth_mul_sequencer #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .is_signed   (is_signed),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .busy        (busy),
        .done        (done),
        .product_hi  (product_hi),
        .product_lo  (product_lo)
    );

    always @(negedge clock) if (busy && done) overlap_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Called at the negedge of the first cycle after acceptance; returns the cycle count at done.
    task automatic wait_done(input int pulse_at, output int cyc, output int busy_cyc);
        cyc = 1;
        busy_cyc = 0;
        while (!done && cyc < 60) begin
            if (busy) busy_cyc++;
            if (pulse_at >= 0) start = (cyc == pulse_at);
            @(negedge clock);
            cyc++;
        end
        if (pulse_at >= 0) start = 1'b0;
    endtask

    task automatic do_mul(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [63:0] exp, input int pulse_at);
        int cyc, bc;
        start = 1'b1;
        is_signed = s;
        multiplicand = a;
        multiplier = b;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        multiplicand = $urandom;
        multiplier = $urandom;
        is_signed = $urandom_range(0, 1);
        wait_done(pulse_at, cyc, bc);
        check({tag, "_latency"}, 64'(cyc), s ? 64'(W / 2 + 1) : 64'(W / 2 + 2));
        check({tag, "_busy_cycles"}, 64'(bc), s ? 64'(W / 2) : 64'(W / 2 + 1));
        check({tag, "_product"}, {product_hi, product_lo}, exp);
        @(negedge clock);
        check({tag, "_idle_after"}, {62'b0, busy, done}, 64'd0);
        check({tag, "_hold"}, {product_hi, product_lo}, exp);
    endtask

    logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    initial begin
        int cyc, bc, dcount;
        logic [W-1:0] a, b, c, d;
        logic s;

        clear = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        multiplicand = '0;
        multiplier = '0;
        repeat (2) @(negedge clock);
        check("reset_outputs", {product_hi, product_lo}, 64'd0);
        check("reset_flags", {62'b0, busy, done}, 64'd0);
        clear = 1'b0;
        @(negedge clock);

        do_mul("s7xm3", 1'b1, 32'h7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, -1);
        do_mul("u_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
        do_mul("s_ff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, -1);
        do_mul("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1);
        do_mul("s_minmax", 1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, -1);
        do_mul("run_pulse", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, ref_prod(1'b0, 32'h1234_5678, 32'h9ABC_DEF0), 5);

        // Start held high throughout: operands change mid-run, second op launches from DONE.
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        start = 1'b1; is_signed = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clock);
        @(negedge clock);
        is_signed = 1'b0; multiplicand = c; multiplier = d;
        wait_done(-1, cyc, bc);
        check("b2b_first_latency", 64'(cyc), 64'(W / 2 + 1));
        check("b2b_first_product", {product_hi, product_lo}, ref_prod(1'b1, a, b));
        @(negedge clock);
        check("b2b_no_idle", {63'b0, busy}, 64'd1);
        check("b2b_hold_in_run", {product_hi, product_lo}, ref_prod(1'b1, a, b));
        start = 1'b0;
        wait_done(-1, cyc, bc);
        check("b2b_second_latency", 64'(cyc), 64'(W / 2 + 2));
        check("b2b_second_product", {product_hi, product_lo}, ref_prod(1'b0, c, d));
        @(negedge clock);

        // Abort with clear five cycles into a run.
        start = 1'b1; is_signed = 1'b1; multiplicand = 32'h0BAD_F00D; multiplier = 32'h0000_1001;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        #2 clear = 1'b1;
        #1;
        check("abort_flags", {62'b0, busy, done}, 64'd0);
        check("abort_product", {product_hi, product_lo}, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        dcount = 0;
        repeat (30) begin
            @(negedge clock);
            if (done || busy) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        do_mul("after_abort", 1'b1, 32'hFFFF_FFF0, 32'h0000_0011, ref_prod(1'b1, 32'hFFFF_FFF0, 32'h0000_0011), -1);

        for (int i = 0; i < 400; i++) begin
            s = $urandom_range(0, 1);
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 32'($urandom);
            do_mul(s ? "rand_s" : "rand_u", s, a, b, ref_prod(s, a, b), -1);
        end

        check("busy_done_overlap", 64'(overlap_cnt), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
